// File: rtl/pc_branch_unit.sv
// pc_branch_unit
//   Program counter and branch resolution for the CSE141L core. Holds ProgCtr
//   and picks the next fetch address (increment, relative branch or absolute
//   branch), sequences IDLE -> RUN -> DONE around the Start/Done handshake,
//   and keeps a saturating count of taken branches since the last Start.
// Ports
//   Clk, Reset            clock, synchronous active-high reset
//   Start                 begin execution at START_ADDR (from IDLE or DONE)
//   Halt, Stall           halt instruction at ProgCtr / freeze PC this cycle
//   BranchEn, BranchAbs   conditional branch present / absolute vs relative
//   Jump                  ALU branch condition, 1 = take
//   Offset [OW]           signed relative displacement
//   Target [PW]           absolute branch address
//   ProgCtr [PW]          current fetch address
//   Running, Done         registered state flags
//   Taken                 one-cycle pulse after a taken-branch edge
//   BranchCount [CW]      saturating taken-branch count
module pc_branch_unit #(
  parameter int unsigned     PW         = 10,
  parameter int unsigned     OW         = 8,
  parameter int unsigned     CW         = 8,
  parameter logic [PW-1:0]   START_ADDR = '0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Halt,
  input  logic          Stall,
  input  logic          BranchEn,
  input  logic          BranchAbs,
  input  logic          Jump,
  input  logic [OW-1:0] Offset,
  input  logic [PW-1:0] Target,
  output logic [PW-1:0] ProgCtr,
  output logic          Running,
  output logic          Done,
  output logic          Taken,
  output logic [CW-1:0] BranchCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_pc;
  logic [PW-1:0] w_pc_nxt;
  logic          r_taken;
  logic          w_taken_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic          r_running;
  logic          r_done;

  logic          w_take;
  logic [PW-1:0] w_offset_ext;
  logic [PW-1:0] w_pc_rel;
  logic [PW-1:0] w_pc_inc;
  logic [PW-1:0] w_pc_branch;
  logic [CW-1:0] w_count_inc;

  // BranchEn gates Jump first so an unknown condition from an illegal ALU op
  // can never steer the PC mux when no branch is decoded.
  assign w_take       = BranchEn & Jump;
  assign w_offset_ext = PW'($signed(Offset));
  assign w_pc_rel     = r_pc + w_offset_ext;
  assign w_pc_inc     = r_pc + PW'(1);
  assign w_pc_branch  = BranchAbs ? Target : w_pc_rel;
  assign w_count_inc  = (r_count == '1) ? r_count : r_count + CW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_taken_nxt = 1'b0;
    w_count_nxt = r_count;
    unique case (r_state)
      IDLE: begin
        w_pc_nxt = START_ADDR;
        if (Start) begin
          w_state_nxt = RUN;
          w_count_nxt = '0;
        end
      end
      RUN: begin
        if (Halt) begin
          w_state_nxt = DONE;
        end else if (Stall) begin
          w_pc_nxt = r_pc;
        end else if (w_take) begin
          w_pc_nxt    = w_pc_branch;
          w_taken_nxt = 1'b1;
          w_count_nxt = w_count_inc;
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end
      DONE: begin
        if (Start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = START_ADDR;
          w_count_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_pc_nxt    = START_ADDR;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_pc      <= START_ADDR;
      r_taken   <= 1'b0;
      r_count   <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_taken   <= w_taken_nxt;
      r_count   <= w_count_nxt;
      r_running <= (w_state_nxt == RUN);
      r_done    <= (w_state_nxt == DONE);
    end
  end

  assign ProgCtr     = r_pc;
  assign Running     = r_running;
  assign Done        = r_done;
  assign Taken       = r_taken;
  assign BranchCount = r_count;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: each stimulus cycle pushes the outputs
// expected after the next rising edge; a monitor pops and compares them.
module tb_pc_branch_unit;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       Halt = 1'b0;
  logic       Stall = 1'b0;
  logic       BranchEn = 1'b0;
  logic       BranchAbs = 1'b0;
  logic       Jump = 1'b0;
  logic [7:0] Offset = '0;
  logic [9:0] Target = '0;
  logic [9:0] ProgCtr;
  logic       Running;
  logic       Done;
  logic       Taken;
  logic [7:0] BranchCount;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned step_id  = 0;

  typedef struct {
    int unsigned id;
    logic [9:0]  pc;
    logic        run;
    logic        dn;
    logic        tk;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q[$];

  pc_branch_unit #(
    .PW(10),
    .OW(8),
    .CW(8),
    .START_ADDR(10'd0)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Start(Start),
    .Halt(Halt),
    .Stall(Stall),
    .BranchEn(BranchEn),
    .BranchAbs(BranchAbs),
    .Jump(Jump),
    .Offset(Offset),
    .Target(Target),
    .ProgCtr(ProgCtr),
    .Running(Running),
    .Done(Done),
    .Taken(Taken),
    .BranchCount(BranchCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int unsigned id,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, id, act, exp);
    end
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ProgCtr",     e.id, 32'(ProgCtr),     32'(e.pc));
        chk("Running",     e.id, 32'(Running),     32'(e.run));
        chk("Done",        e.id, 32'(Done),        32'(e.dn));
        chk("Taken",       e.id, 32'(Taken),       32'(e.tk));
        chk("BranchCount", e.id, 32'(BranchCount), 32'(e.cnt));
      end
    end
  end

  // One cycle: drive inputs on the falling edge and queue the outputs
  // expected after the following rising edge.
  task automatic cyc(input logic rst, input logic st, input logic h,
                     input logic s, input logic be, input logic ba,
                     input logic j, input logic [7:0] off,
                     input logic [9:0] tgt, input logic [9:0] pc,
                     input logic run, input logic dn, input logic tk,
                     input logic [7:0] cnt);
    exp_t e;
    @(negedge Clk);
    Reset = rst; Start = st; Halt = h; Stall = s;
    BranchEn = be; BranchAbs = ba; Jump = j; Offset = off; Target = tgt;
    step_id++;
    e.id = step_id; e.pc = pc; e.run = run; e.dn = dn; e.tk = tk; e.cnt = cnt;
    q.push_back(e);
  endtask

  initial begin
    int unsigned wait_cycles;
    // reset for two cycles
    cyc(1, 0, 0, 0, 0, 0, 0, 8'h00, 10'd0,    10'd0, 0, 0, 0, 8'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 8'h00, 10'd0,    10'd0, 0, 0, 0, 8'd0);
    // IDLE ignores branch/halt inputs
    cyc(0, 0, 1, 0, 1, 1, 1, 8'h00, 10'd77,   10'd0, 0, 0, 0, 8'd0);
    // start: first fetch at address 0
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h00, 10'd0,    10'd0, 1, 0, 0, 8'd0);
    // five sequential increments
    for (int i = 1; i <= 5; i++)
      cyc(0, 0, 0, 0, 0, 0, 0, 8'h00, 10'd0, 10'(i), 1, 0, 0, 8'd0);
    // 5 - 16 wraps backwards to 1013
    cyc(0, 0, 0, 0, 1, 0, 1, 8'hF0, 10'd0,    10'd1013, 1, 0, 1, 8'd1);
    // absolute to 300, then to 20
    cyc(0, 0, 0, 0, 1, 1, 1, 8'h00, 10'd300,  10'd300, 1, 0, 1, 8'd2);
    cyc(0, 0, 0, 0, 1, 1, 1, 8'h00, 10'd20,   10'd20,  1, 0, 1, 8'd3);
    // 20 - 10 = 10
    cyc(0, 0, 0, 0, 1, 0, 1, 8'hF6, 10'd0,    10'd10,  1, 0, 1, 8'd4);
    // Taken drops after one cycle
    cyc(0, 0, 0, 0, 0, 0, 0, 8'h00, 10'd0,    10'd11,  1, 0, 0, 8'd4);
    // Jump unknown / set but BranchEn low: plain increment
    cyc(0, 0, 0, 0, 0, 1, 1'bx, 8'h40, 10'd500, 10'd12, 1, 0, 0, 8'd4);
    cyc(0, 0, 0, 0, 0, 1, 1, 8'h40, 10'd500,  10'd13,  1, 0, 0, 8'd4);
    // branch taken but not jump: increment
    cyc(0, 0, 0, 0, 1, 1, 0, 8'h00, 10'd500,  10'd14,  1, 0, 0, 8'd4);
    // stall overrides a taken branch
    cyc(0, 0, 0, 1, 1, 1, 1, 8'h00, 10'd500,  10'd14,  1, 0, 0, 8'd4);
    // offset 0 taken: self loop
    cyc(0, 0, 0, 0, 1, 0, 1, 8'h00, 10'd0,    10'd14,  1, 0, 1, 8'd5);
    // increment wrap 1023 -> 0
    cyc(0, 0, 0, 0, 1, 1, 1, 8'h00, 10'd1021, 10'd1021, 1, 0, 1, 8'd6);
    cyc(0, 0, 0, 0, 0, 0, 0, 8'h00, 10'd0,    10'd1022, 1, 0, 0, 8'd6);
    cyc(0, 0, 0, 0, 0, 0, 0, 8'h00, 10'd0,    10'd1023, 1, 0, 0, 8'd6);
    cyc(0, 0, 0, 0, 0, 0, 0, 8'h00, 10'd0,    10'd0,    1, 0, 0, 8'd6);
    // forward relative wrap: 1020 + 7 = 3
    cyc(0, 0, 0, 0, 1, 1, 1, 8'h00, 10'd1020, 10'd1020, 1, 0, 1, 8'd7);
    cyc(0, 0, 0, 0, 1, 0, 1, 8'h07, 10'd0,    10'd3,    1, 0, 1, 8'd8);
    // halt with stall and taken branch at 42
    cyc(0, 0, 0, 0, 1, 1, 1, 8'h00, 10'd42,   10'd42,   1, 0, 1, 8'd9);
    cyc(0, 0, 1, 1, 1, 1, 1, 8'h00, 10'd99,   10'd42,   0, 1, 0, 8'd9);
    // DONE ignores halt/branch inputs
    cyc(0, 0, 1, 0, 1, 1, 1, 8'h00, 10'd99,   10'd42,   0, 1, 0, 8'd9);
    // restart from DONE
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h00, 10'd0,    10'd0,    1, 0, 0, 8'd0);
    // Start in RUN ignored
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h00, 10'd0,    10'd1,    1, 0, 0, 8'd0);
    // 300 taken self-loop branches: count saturates at 255
    for (int i = 1; i <= 300; i++)
      cyc(0, 0, 0, 0, 1, 0, 1, 8'h00, 10'd0, 10'd1, 1, 0, 1,
          (i < 255) ? 8'(i) : 8'd255);
    cyc(0, 0, 1, 0, 0, 0, 0, 8'h00, 10'd0,    10'd1,    0, 1, 0, 8'd255);
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h00, 10'd0,    10'd0,    1, 0, 0, 8'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 8'h00, 10'd0,    10'd1,    1, 0, 0, 8'd0);
    cyc(0, 0, 0, 0, 1, 1, 1, 8'h00, 10'd600,  10'd600,  1, 0, 1, 8'd1);
    // reset mid-run wins over start and branch
    cyc(1, 1, 0, 0, 1, 1, 1, 8'h00, 10'd700,  10'd0,    0, 0, 0, 8'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 8'h00, 10'd0,    10'd0,    0, 0, 0, 8'd0);

    wait_cycles = 0;
    while (q.size() > 0 && wait_cycles < 20) begin
      @(posedge Clk);
      #2;
      wait_cycles++;
    end
    n_checks++;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
